// File: rtl/adc_timing_pkg.sv
// Shared timing defaults and FSM state encoding for the ADC sample sequencer.
package adc_timing_pkg;

    localparam int DEF_SAMPLE_PERIOD   = 1000;
    localparam int DEF_SAMPLES_PER_PPS = 1000;
    localparam int DEF_CONVST_WIDTH    = 4;
    localparam int DEF_BUSY_TIMEOUT    = 200;
    localparam int DEF_IDX_W           = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PPS,
        CONV_START,
        CONVERTING,
        HOLDOFF
    } seq_state_e;

    // Bits needed by a counter whose largest value is n-1.
    function automatic int cnt_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/neg_edge_detector.sv
// Falling-edge detector: one-cycle NEGEDGE when SIG drops (registered 1, current 0).
module neg_edge_detector (
    input  logic CLK,
    input  logic RST,
    input  logic SIG,
    output logic NEGEDGE
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = SIG;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign NEGEDGE = sig_q & ~SIG;

endmodule

// File: rtl/adc_sample_sequencer.sv
// PPS-aligned ADC conversion sequencer: paces CONVST, watches BUSY and
// flags lost PPS alignment or a stuck converter.
module adc_sample_sequencer
    import adc_timing_pkg::*;
#(
    parameter int SAMPLE_PERIOD   = DEF_SAMPLE_PERIOD,
    parameter int SAMPLES_PER_PPS = DEF_SAMPLES_PER_PPS,
    parameter int CONVST_WIDTH    = DEF_CONVST_WIDTH,
    parameter int BUSY_TIMEOUT    = DEF_BUSY_TIMEOUT,
    parameter int IDX_W           = DEF_IDX_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic             PPS_EDGE,
    input  logic             ADC_BUSY,
    output logic             CONVST,
    output logic             SAMPLE_READY,
    output logic [IDX_W-1:0] SAMPLE_IDX,
    output logic             SYNC_ERR,
    output logic             TIMEOUT_ERR
);

    localparam int PW = cnt_w(SAMPLE_PERIOD);
    localparam int WW = cnt_w(CONVST_WIDTH);
    localparam int TW = cnt_w(BUSY_TIMEOUT);

    localparam logic [PW-1:0]    PERIOD_LD = PW'(SAMPLE_PERIOD - 1);
    localparam logic [WW-1:0]    WIDTH_LD  = WW'(CONVST_WIDTH - 1);
    localparam logic [TW-1:0]    TIMER_MAX = TW'(BUSY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SAMPLES_PER_PPS - 1);

    if (SAMPLE_PERIOD < CONVST_WIDTH + BUSY_TIMEOUT + 2) begin : g_bad_period
        $error("SAMPLE_PERIOD must be >= CONVST_WIDTH + BUSY_TIMEOUT + 2");
    end

    if (CONVST_WIDTH < 1 || BUSY_TIMEOUT < 1) begin : g_bad_width
        $error("CONVST_WIDTH and BUSY_TIMEOUT must be at least 1");
    end

    if (SAMPLES_PER_PPS < 1 ||
        (IDX_W < 31 && SAMPLES_PER_PPS > (1 << IDX_W))) begin : g_bad_count
        $error("SAMPLES_PER_PPS must be in 1 .. 2**IDX_W");
    end

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic             convst_q;
    logic             convst_d;
    logic             ready_q;
    logic             ready_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic             sync_q;
    logic             sync_d;
    logic             tout_q;
    logic             tout_d;
    logic [PW-1:0]    period_q;
    logic [PW-1:0]    period_d;
    logic [WW-1:0]    width_q;
    logic [WW-1:0]    width_d;
    logic [TW-1:0]    timer_q;
    logic [TW-1:0]    timer_d;

    logic             busy_fall;
    logic             restart;

    neg_edge_detector u_busy_fall (
        .CLK     (CLK),
        .RST     (RST),
        .SIG     (ADC_BUSY),
        .NEGEDGE (busy_fall)
    );

    always_comb begin
        state_d  = state_q;
        convst_d = convst_q;
        ready_d  = 1'b0;
        idx_d    = idx_q;
        sync_d   = sync_q;
        tout_d   = tout_q;
        width_d  = width_q;
        timer_d  = timer_q;
        period_d = (period_q == '0) ? '0 : period_q - PW'(1);
        restart  = PPS_EDGE && (state_q != IDLE);

        if (!ENABLE) begin
            state_d  = IDLE;
            convst_d = 1'b0;
            idx_d    = '0;
            sync_d   = 1'b0;
            tout_d   = 1'b0;
            width_d  = '0;
            timer_d  = '0;
            period_d = '0;
        end else if (restart) begin
            // PPS outranks everything, including a coincident BUSY fall.
            state_d  = CONV_START;
            convst_d = 1'b1;
            idx_d    = '0;
            period_d = PERIOD_LD;
            width_d  = WIDTH_LD;
            sync_d   = sync_q | (state_q != WAIT_PPS);
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WAIT_PPS;
                end
                WAIT_PPS: begin
                    state_d = WAIT_PPS;
                end
                CONV_START: begin
                    if (width_q == '0) begin
                        state_d  = CONVERTING;
                        convst_d = 1'b0;
                        timer_d  = '0;
                    end else begin
                        width_d = width_q - WW'(1);
                    end
                end
                CONVERTING: begin
                    if (busy_fall) begin
                        ready_d = 1'b1;
                        state_d = (idx_q == IDX_LAST) ? WAIT_PPS : HOLDOFF;
                    end else if (timer_q == TIMER_MAX) begin
                        tout_d  = 1'b1;
                        state_d = (idx_q == IDX_LAST) ? WAIT_PPS : HOLDOFF;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                HOLDOFF: begin
                    if (period_q == '0) begin
                        state_d  = CONV_START;
                        convst_d = 1'b1;
                        idx_d    = idx_q + IDX_W'(1);
                        period_d = PERIOD_LD;
                        width_d  = WIDTH_LD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            convst_q <= 1'b0;
            ready_q  <= 1'b0;
            idx_q    <= '0;
            sync_q   <= 1'b0;
            tout_q   <= 1'b0;
            period_q <= '0;
            width_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            convst_q <= convst_d;
            ready_q  <= ready_d;
            idx_q    <= idx_d;
            sync_q   <= sync_d;
            tout_q   <= tout_d;
            period_q <= period_d;
            width_q  <= width_d;
            timer_q  <= timer_d;
        end
    end

    assign CONVST       = convst_q;
    assign SAMPLE_READY = ready_q;
    assign SAMPLE_IDX   = idx_q;
    assign SYNC_ERR     = sync_q;
    assign TIMEOUT_ERR  = tout_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: timeline model of the sequencer checked
// every cycle, plus directed scenarios pinned with hand-computed cycle numbers.
module tb_adc_sample_sequencer;

    localparam int P  = 10;
    localparam int N  = 4;
    localparam int W  = 2;
    localparam int T  = 5;
    localparam int IW = 16;
    localparam int HN = 80;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          ENABLE = 1'b0;
    logic          PPS_EDGE = 1'b0;
    logic          ADC_BUSY = 1'b0;
    logic          CONVST;
    logic          SAMPLE_READY;
    logic [IW-1:0] SAMPLE_IDX;
    logic          SYNC_ERR;
    logic          TIMEOUT_ERR;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;

    bit h_cv[HN];
    bit h_rdy[HN];
    bit h_sync[HN];
    bit h_tout[HN];
    int h_idx[HN];

    int busy_left = 0;
    int skip      = -1;
    int conv_no   = 0;
    bit cv_prev   = 1'b0;
    bit rnd_busy  = 1'b0;

    adc_sample_sequencer #(
        .SAMPLE_PERIOD   (P),
        .SAMPLES_PER_PPS (N),
        .CONVST_WIDTH    (W),
        .BUSY_TIMEOUT    (T),
        .IDX_W           (IW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ENABLE       (ENABLE),
        .PPS_EDGE     (PPS_EDGE),
        .ADC_BUSY     (ADC_BUSY),
        .CONVST       (CONVST),
        .SAMPLE_READY (SAMPLE_READY),
        .SAMPLE_IDX   (SAMPLE_IDX),
        .SYNC_ERR     (SYNC_ERR),
        .TIMEOUT_ERR  (TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Timeline model: a run is a PPS start time plus conversion k whose
    // CONVST rose at m_rise; everything follows from offsets to that time.
    bit m_armed = 0;
    bit m_run   = 0;
    bit m_done  = 0;
    bit m_pb    = 0;
    int m_t     = 0;
    int m_rise  = 0;
    int m_k     = 0;
    bit e_convst = 0;
    bit e_ready  = 0;
    bit e_sync   = 0;
    bit e_tout   = 0;
    int e_idx    = 0;

    always @(posedge CLK or posedge RST) begin : model
        bit fall;
        int off;
        if (RST) begin
            m_armed  = 0;
            m_run    = 0;
            m_done   = 0;
            m_pb     = 0;
            e_convst = 0;
            e_ready  = 0;
            e_sync   = 0;
            e_tout   = 0;
            e_idx    = 0;
        end else begin
            fall  = m_pb && !ADC_BUSY;
            m_pb  = ADC_BUSY;
            off   = m_t - m_rise;
            m_t   = m_t + 1;
            e_ready = 0;
            if (!ENABLE) begin
                m_armed = 0;
                m_run   = 0;
                e_idx   = 0;
                e_sync  = 0;
                e_tout  = 0;
            end else if (!m_armed) begin
                m_armed = 1;
            end else if (PPS_EDGE) begin
                if (m_run) e_sync = 1;
                m_run  = 1;
                m_rise = m_t;
                m_k    = 0;
                m_done = 0;
                e_idx  = 0;
            end else if (m_run) begin
                if (!m_done && off >= W && off <= W + T - 1 && fall) begin
                    e_ready = 1;
                    m_done  = 1;
                end else if (!m_done && off == W + T - 1) begin
                    e_tout = 1;
                    m_done = 1;
                end
                if (m_done && m_k == N - 1) begin
                    m_run = 0;
                end else if (m_t - m_rise == P) begin
                    m_rise = m_t;
                    m_k    = m_k + 1;
                    m_done = 0;
                    e_idx  = m_k;
                end
            end
            e_convst = m_run && (m_t - m_rise) < W;
        end
    end

    always @(negedge CLK) begin : compare
        int rel;
        n_cmp = n_cmp + 1;
        if (CONVST !== e_convst || SAMPLE_READY !== e_ready ||
            SAMPLE_IDX !== IW'(e_idx) || SYNC_ERR !== e_sync ||
            TIMEOUT_ERR !== e_tout) begin
            n_err = n_err + 1;
            $display("FAIL model cyc %0d: got cv=%b rdy=%b idx=%0d sync=%b tout=%b want cv=%b rdy=%b idx=%0d sync=%b tout=%b",
                     cyc, CONVST, SAMPLE_READY, SAMPLE_IDX, SYNC_ERR, TIMEOUT_ERR,
                     e_convst, e_ready, e_idx, e_sync, e_tout);
        end
        rel = cyc - t0;
        if (rel >= 0 && rel < HN) begin
            h_cv[rel]   = CONVST;
            h_rdy[rel]  = SAMPLE_READY;
            h_sync[rel] = SYNC_ERR;
            h_tout[rel] = TIMEOUT_ERR;
            h_idx[rel]  = int'(SAMPLE_IDX);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp = n_cmp + 1;
        if (got != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic chk_s(input string nm, input string got, input string exp);
        n_cmp = n_cmp + 1;
        if (got != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got '%s' want '%s'", nm, got, exp);
        end
    endtask

    function automatic string rises_str();
        string s = "";
        for (int r = 0; r < HN; r++)
            if (h_cv[r] && (r == 0 || !h_cv[r-1]))
                s = {s, $sformatf(" %0d", r)};
        return s;
    endfunction

    function automatic string ready_str();
        string s = "";
        for (int r = 0; r < HN; r++)
            if (h_rdy[r])
                s = {s, $sformatf(" %0d:%0d", r, h_idx[r])};
        return s;
    endfunction

    // Also plays the ADC: BUSY goes high when CONVST falls.
    task automatic tick();
        @(posedge CLK);
        #2;
        PPS_EDGE = 1'b0;
        if (cv_prev && !CONVST) begin
            if (conv_no == skip) busy_left = 0;
            else if (rnd_busy) busy_left = int'($urandom_range(0, 7));
            else busy_left = 3;
            conv_no = conv_no + 1;
        end
        cv_prev  = CONVST;
        ADC_BUSY = (busy_left > 0);
        if (busy_left > 0) busy_left = busy_left - 1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic pps_at0();
        tick();
        t0 = cyc;
        for (int r = 0; r < HN; r++) begin
            h_cv[r]   = 0;
            h_rdy[r]  = 0;
            h_sync[r] = 0;
            h_tout[r] = 0;
            h_idx[r]  = 0;
        end
        conv_no  = 0;
        PPS_EDGE = 1'b1;
    endtask

    initial begin
        int quiet;
        RST = 1'b1;
        ticks(3);
        chk("reset_convst", int'(CONVST), 0);
        chk("reset_ready", int'(SAMPLE_READY), 0);
        chk("reset_idx", int'(SAMPLE_IDX), 0);
        chk("reset_sync", int'(SYNC_ERR), 0);
        chk("reset_tout", int'(TIMEOUT_ERR), 0);
        RST = 1'b0;
        tick();
        ENABLE = 1'b1;
        ticks(2);

        pps_at0();
        ticks(61);
        chk_s("nominal_rises", rises_str(), " 1 11 21 31");
        chk_s("nominal_ready", ready_str(), " 7:0 17:1 27:2 37:3");
        chk("nominal_sync", int'(h_sync[60]), 0);

        pps_at0();
        ticks(15);
        PPS_EDGE = 1'b1;
        ticks(46);
        chk_s("early_rises", rises_str(), " 1 11 16 26 36 46");
        chk_s("early_ready", ready_str(), " 7:0 22:0 32:1 42:2 52:3");
        chk("early_sync15", int'(h_sync[15]), 0);
        chk("early_sync16", int'(h_sync[16]), 1);
        chk("early_idx16", h_idx[16], 0);

        skip = 1;
        pps_at0();
        ticks(61);
        skip = -1;
        chk_s("tout_rises", rises_str(), " 1 11 21 31");
        chk_s("tout_ready", ready_str(), " 7:0 27:2 37:3");
        chk("tout_flag17", int'(h_tout[17]), 0);
        chk("tout_flag18", int'(h_tout[18]), 1);

        pps_at0();
        tick();
        ENABLE = 1'b0;
        tick();
        tick();
        ENABLE = 1'b1;
        ticks(5);
        chk("dis_cv1", int'(h_cv[1]), 1);
        chk("dis_cv2", int'(h_cv[2]), 0);
        chk("dis_sync1", int'(h_sync[1]), 1);
        chk("dis_sync2", int'(h_sync[2]), 0);
        chk("dis_tout1", int'(h_tout[1]), 1);
        chk("dis_tout2", int'(h_tout[2]), 0);

        pps_at0();
        ticks(2);
        PPS_EDGE = 1'b1;
        ticks(4);
        chk("rst_pre_sync", int'(SYNC_ERR), 1);
        chk("rst_pre_cv", int'(h_cv[3]), 1);
        RST = 1'b1;
        #1;
        chk("rst_async_cv", int'(CONVST), 0);
        chk("rst_async_sync", int'(SYNC_ERR), 0);
        chk("rst_async_idx", int'(SAMPLE_IDX), 0);
        tick();
        RST = 1'b0;
        ticks(21);
        quiet = 0;
        for (int r = 7; r < 28; r++) quiet += int'(h_cv[r]);
        chk("rst_no_convst", quiet, 0);
        pps_at0();
        ticks(45);
        chk_s("rst_restart", rises_str(), " 1 11 21 31");

        pps_at0();
        ticks(6);
        PPS_EDGE = 1'b1;
        ticks(10);
        chk("coin_sync6", int'(h_sync[6]), 0);
        chk("coin_sync7", int'(h_sync[7]), 1);
        chk("coin_ready7", int'(h_rdy[7]), 0);
        chk("coin_cv7", int'(h_cv[7]), 1);
        chk("coin_idx7", h_idx[7], 0);
        ticks(40);

        rnd_busy = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 49) == 0) PPS_EDGE = 1'b1;
            if ($urandom_range(0, 299) == 0) ENABLE = 1'b0;
            else if (!ENABLE && $urandom_range(0, 3) == 0) ENABLE = 1'b1;
            if ($urandom_range(0, 799) == 0) begin
                RST = 1'b1;
                #2;
                RST = 1'b0;
            end
        end
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
